// File: rtl/regfile_write_arbiter_if.sv
`timescale 1ns/1ps
// regfile_write_arbiter_if
//   Bundles the two writeback requester handshakes and the register_file
//   write port driven by regfile_write_arbiter.
//   slave  : the arbiter (consumes requests, drives ready/write port/init_done)
//   master : the environment (drives requests, observes ready/write port)
//   Signals:
//     req0_valid/req0_rd/req0_data, req0_ready   requester 0 (ALU)
//     req1_valid/req1_rd/req1_data, req1_ready   requester 1 (load unit)
//     rf_we/rf_rd/rf_rd_data                      register_file write port
//     init_done                                   high while arbiter is in RUN
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_rd_data;
    logic              init_done;

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_rd, rf_rd_data, init_done
    );

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_rd, rf_rd_data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// regfile_write_arbiter
//   Owns the single write port of register_file. After reset (or a clear
//   pulse while running) it sweeps zero into every register, then arbitrates
//   round-robin between two writeback requesters with valid/ready handshakes.
//   Ports:
//     clk    in  rising-edge clock
//     rst    in  asynchronous active-high reset
//     clear  in  pulse: re-run the zero sweep (ignored during the sweep)
//     bus    slave side of regfile_write_arbiter_if (requests, write port,
//            init_done)
module regfile_write_arbiter #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    regfile_write_arbiter_if.slave  bus
);
    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam state_t            RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;
    localparam logic              RST_DONE  = (INIT_ZERO == 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              last_grant, last_grant_nxt;   // 1: requester 1 won last
    logic              we_nxt;
    logic [ADDR_W-1:0] rd_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              done_nxt;

    logic clear_eff;
    logic accept_ok;
    logic grant0, grant1;

    // Clear only matters when a sweep exists to re-run.
    assign clear_eff = clear && (INIT_ZERO != 0);
    assign accept_ok = (state == S_RUN) && !clear_eff;

    // Round-robin: a lone requester always wins; on a tie the one that did
    // not win last time goes. Grants are mutually exclusive by construction.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = accept_ok && grant0;
    assign bus.req1_ready = accept_ok && grant1;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        we_nxt         = 1'b0;
        rd_nxt         = bus.rf_rd;
        data_nxt       = bus.rf_rd_data;
        done_nxt       = bus.init_done;

        case (state)
            S_INIT: begin
                we_nxt   = 1'b1;
                rd_nxt   = cnt;
                data_nxt = '0;
                if (cnt == LAST_ADDR) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (clear_eff) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                end else if (bus.req0_ready) begin
                    // Writes to x0 are accepted but never reach the file.
                    we_nxt         = (bus.req0_rd != '0);
                    rd_nxt         = bus.req0_rd;
                    data_nxt       = bus.req0_data;
                    last_grant_nxt = 1'b0;
                end else if (bus.req1_ready) begin
                    we_nxt         = (bus.req1_rd != '0);
                    rd_nxt         = bus.req1_rd;
                    data_nxt       = bus.req1_data;
                    last_grant_nxt = 1'b1;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RST_STATE;
            cnt            <= '0;
            last_grant     <= 1'b1;
            bus.rf_we      <= 1'b0;
            bus.rf_rd      <= '0;
            bus.rf_rd_data <= '0;
            bus.init_done  <= RST_DONE;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            last_grant     <= last_grant_nxt;
            bus.rf_we      <= we_nxt;
            bus.rf_rd      <= rd_nxt;
            bus.rf_rd_data <= data_nxt;
            bus.init_done  <= done_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter. Inputs change 1ns after a rising
//   edge; registered outputs are checked there, ready 1ns later. A small
//   register array behind the write port stands in for register_file reads.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic clear;

    int total  = 0;
    int passed = 0;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_write_arbiter #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32),
        .INIT_ZERO(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Stand-in register file: written from the arbiter's write port.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_rd] <= bus.rf_rd_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        idle_reqs();
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5A5_A5A5;
        step();

        // Reset values
        chk("rst_we",   32'(bus.rf_we), 32'd0);
        chk("rst_rd",   32'(bus.rf_rd), 32'd0);
        chk("rst_data", bus.rf_rd_data, 32'd0);
        chk("rst_done", 32'(bus.init_done), 32'd0);

        // 1. Sweep after reset release, requester 0 held valid to prove ready=0
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd3;
        bus.req0_data  = 32'hBAD0_0003;
        for (int k = 0; k < 32; k++) begin
            step();
            chk($sformatf("sweep_we_%0d", k), 32'(bus.rf_we), 32'd1);
            chk($sformatf("sweep_rd_%0d", k), 32'(bus.rf_rd), 32'(k));
            chk($sformatf("sweep_data_%0d", k), bus.rf_rd_data, 32'd0);
            chk($sformatf("sweep_done_%0d", k), 32'(bus.init_done), (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) chk($sformatf("sweep_ready0_%0d", k), 32'(bus.req0_ready), 32'd0);
            if (k == 31) idle_reqs();
        end
        step();
        chk("post_sweep_we",   32'(bus.rf_we), 32'd0);
        chk("post_sweep_done", 32'(bus.init_done), 32'd1);
        chk("post_sweep_x3",   rf_mem[3], 32'd0);
        chk("post_sweep_x31",  rf_mem[31], 32'd0);

        // 2. Requester 0 alone: rd=5, data=DEADBEEF
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 32'hDEAD_BEEF;
        #1;
        chk("t2_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t2_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        idle_reqs();
        chk("t2_we",   32'(bus.rf_we), 32'd1);
        chk("t2_rd",   32'(bus.rf_rd), 32'd5);
        chk("t2_data", bus.rf_rd_data, 32'hDEAD_BEEF);
        step();
        chk("t2_we_low", 32'(bus.rf_we), 32'd0);
        chk("t2_read5",  rf_mem[5], 32'hDEAD_BEEF);

        // 4. Requester 1 writes x0: accepted, dropped
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd0;
        bus.req1_data  = 32'hFFFF_FFFF;
        #1;
        chk("t4_ready1", 32'(bus.req1_ready), 32'd1);
        chk("t4_ready0", 32'(bus.req0_ready), 32'd0);
        step();
        idle_reqs();
        chk("t4_we", 32'(bus.rf_we), 32'd0);
        step();
        chk("t4_read0", rf_mem[0], 32'd0);

        // 3. Both continuously valid: grants 0,1,0,1
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd1;
        bus.req0_data  = 32'h11;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd2;
        bus.req1_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_ready0_%0d", i), 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_ready1_%0d", i), 32'(bus.req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk($sformatf("t3_we_%0d", i),   32'(bus.rf_we), 32'd1);
            chk($sformatf("t3_rd_%0d", i),   32'(bus.rf_rd), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("t3_data_%0d", i), bus.rf_rd_data, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle_reqs();
        step();
        chk("t3_we_low", 32'(bus.rf_we), 32'd0);
        chk("t3_x1", rf_mem[1], 32'h11);
        chk("t3_x2", rf_mem[2], 32'h22);

        // 5. Write x7 then clear with req0 valid in the same cycle as the write
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd7;
        bus.req0_data  = 32'h1234;
        #1;
        chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        chk("t5_we", 32'(bus.rf_we), 32'd1);
        chk("t5_rd", 32'(bus.rf_rd), 32'd7);
        clear          = 1'b1;
        bus.req0_rd    = 5'd9;
        bus.req0_data  = 32'h99;
        #1;
        chk("t5_ready0_clear", 32'(bus.req0_ready), 32'd0);
        step();
        clear = 1'b0;
        chk("t5_clear_we",   32'(bus.rf_we), 32'd0);
        chk("t5_clear_done", 32'(bus.init_done), 32'd0);
        chk("t5_x7_written", rf_mem[7], 32'h1234);
        chk("t5_x9_untouched", rf_mem[9], 32'd0);
        for (int k = 0; k < 32; k++) begin
            step();
            chk($sformatf("t5_sweep_rd_%0d", k), 32'(bus.rf_rd), 32'(k));
            chk($sformatf("t5_sweep_we_%0d", k), 32'(bus.rf_we), 32'd1);
            if (k < 31) chk($sformatf("t5_sweep_ready0_%0d", k), 32'(bus.req0_ready), 32'd0);
            if (k == 31) idle_reqs();
        end
        step();
        chk("t5_done",   32'(bus.init_done), 32'd1);
        chk("t5_x7_zero", rf_mem[7], 32'd0);
        chk("t5_x5_zero", rf_mem[5], 32'd0);

        // 6. Async reset mid-sweep at address 10, sweep restarts from 0
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_clear_we", 32'(bus.rf_we), 32'd0);
        for (int k = 0; k <= 10; k++) begin
            step();
            chk($sformatf("t6_sweep_rd_%0d", k), 32'(bus.rf_rd), 32'(k));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_we",   32'(bus.rf_we), 32'd0);
        chk("t6_async_rd",   32'(bus.rf_rd), 32'd0);
        chk("t6_async_data", bus.rf_rd_data, 32'd0);
        chk("t6_async_done", 32'(bus.init_done), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_restart_we", 32'(bus.rf_we), 32'd1);
        chk("t6_restart_rd", 32'(bus.rf_rd), 32'd0);
        step();
        chk("t6_restart_rd1", 32'(bus.rf_rd), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
